// File: rtl/core_alu_arbiter.sv
// Round-robin arbiter that shares one registered ALU among N_REQ requesters and
// returns tagged results through a small show-ahead FIFO with credit-based issue.
module core_alu_arbiter #(
    parameter int W     = 16,
    parameter int N_REQ = 4,
    parameter int IMM_W = 8,
    parameter int RD_W  = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*3-1:0]         req_op,
    input  logic [N_REQ*W-1:0]         req_a,
    input  logic [N_REQ*W-1:0]         req_b,
    input  logic [N_REQ*IMM_W-1:0]     req_imm,
    input  logic [N_REQ-1:0]           req_uses_imm,
    input  logic [N_REQ*RD_W-1:0]      req_rd,
    output logic                       alu_start,
    output logic [2:0]                 alu_op,
    output logic [W-1:0]               alu_a,
    output logic [W-1:0]               alu_b,
    output logic [IMM_W-1:0]           alu_imm,
    output logic                       alu_uses_imm,
    output logic [RD_W-1:0]            alu_rd,
    input  logic [W-1:0]               alu_wb_value,
    input  logic [RD_W-1:0]            alu_wb_rd,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [RD_W-1:0]            rsp_rd,
    output logic [W-1:0]               rsp_value
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [RD_W-1:0] rd;
        logic [W-1:0]    value;
    } rsp_entry_t;

    logic [ID_W-1:0]  rr_ptr;
    logic             inflight;
    logic [ID_W-1:0]  id_q;

    logic [2:0]       op_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [IMM_W-1:0] imm_q;
    logic             uses_imm_q;
    logic [RD_W-1:0]  rd_q;

    rsp_entry_t       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    logic             push;
    logic             pop;
    logic [CNT_W:0]   credit_used;
    logic             issue_ok;
    logic             grant_vld;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    rsp_entry_t       head;

    assign push        = inflight;
    assign rsp_valid   = (fifo_count != '0);
    assign pop         = rsp_valid && rsp_ready;
    assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign issue_ok    = credit_used < (CNT_W+1)'(DEPTH);

    // Search upward from the pointer; the first valid requester wins.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch can be inferred.
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        grant_vld = grant_vld && issue_ok && !rst;
    end

    assign req_ready    = N_REQ'(grant_vld) << grant_idx;
    assign alu_start    = grant_vld;
    assign alu_op       = grant_vld ? req_op[int'(grant_idx)*3 +: 3]            : op_q;
    assign alu_a        = grant_vld ? req_a[int'(grant_idx)*W +: W]             : a_q;
    assign alu_b        = grant_vld ? req_b[int'(grant_idx)*W +: W]             : b_q;
    assign alu_imm      = grant_vld ? req_imm[int'(grant_idx)*IMM_W +: IMM_W]   : imm_q;
    assign alu_uses_imm = grant_vld ? req_uses_imm[grant_idx]                   : uses_imm_q;
    assign alu_rd       = grant_vld ? req_rd[int'(grant_idx)*RD_W +: RD_W]      : rd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            inflight   <= 1'b0;
            id_q       <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            uses_imm_q <= 1'b0;
            rd_q       <= '0;
        end else begin
            inflight <= grant_vld;
            if (grant_vld) begin
                rr_ptr     <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                id_q       <= grant_idx;
                op_q       <= alu_op;
                a_q        <= alu_a;
                b_q        <= alu_b;
                imm_q      <= alu_imm;
                uses_imm_q <= alu_uses_imm;
                rd_q       <= alu_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{id: id_q, rd: alu_wb_rd, value: alu_wb_value};
    end

    assign head      = fifo_mem[rd_ptr];
    assign rsp_id    = head.id;
    assign rsp_rd    = head.rd;
    assign rsp_value = head.value;

endmodule

// File: tb/tb_core_alu_arbiter.sv
// Bench for core_alu_arbiter: ALU stub, queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_core_alu_arbiter;

    localparam int W     = 16;
    localparam int N     = 4;
    localparam int IMM_W = 8;
    localparam int RD_W  = 4;
    localparam int DEPTH = 2;
    localparam int ID_W  = 2;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ORR = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_SHL = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd4;
    localparam logic [2:0] OP_ADD = 3'd5;
    localparam logic [2:0] OP_SUB = 3'd6;

    logic                  clk;
    logic                  rst;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N*3-1:0]        req_op;
    logic [N*W-1:0]        req_a;
    logic [N*W-1:0]        req_b;
    logic [N*IMM_W-1:0]    req_imm;
    logic [N-1:0]          req_uses_imm;
    logic [N*RD_W-1:0]     req_rd;
    logic                  alu_start;
    logic [2:0]            alu_op;
    logic [W-1:0]          alu_a;
    logic [W-1:0]          alu_b;
    logic [IMM_W-1:0]      alu_imm;
    logic                  alu_uses_imm;
    logic [RD_W-1:0]       alu_rd;
    logic [W-1:0]          alu_wb_value;
    logic [RD_W-1:0]       alu_wb_rd;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [RD_W-1:0]       rsp_rd;
    logic [W-1:0]          rsp_value;

    logic [2:0]            op_r  [N];
    logic [W-1:0]          a_r   [N];
    logic [W-1:0]          b_r   [N];
    logic [IMM_W-1:0]      imm_r [N];
    logic                  ui_r  [N];
    logic [RD_W-1:0]       rd_r  [N];

    int n_checks = 0;
    int n_err    = 0;

    core_alu_arbiter #(.W(W), .N_REQ(N), .IMM_W(IMM_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
        .req_uses_imm(req_uses_imm), .req_rd(req_rd),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_imm(alu_imm), .alu_uses_imm(alu_uses_imm), .alu_rd(alu_rd),
        .alu_wb_value(alu_wb_value), .alu_wb_rd(alu_wb_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_rd(rsp_rd), .rsp_value(rsp_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_op[i*3 +: 3]         = op_r[i];
            req_a[i*W +: W]          = a_r[i];
            req_b[i*W +: W]          = b_r[i];
            req_imm[i*IMM_W +: IMM_W] = imm_r[i];
            req_uses_imm[i]          = ui_r[i];
            req_rd[i*RD_W +: RD_W]   = rd_r[i];
        end
    end

    function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [IMM_W-1:0] imm,
                                             input logic uses_imm);
        logic [W-1:0] bb;
        bb = (uses_imm && (op inside {OP_SHL, OP_SHR, OP_ADD, OP_SUB})) ? W'(imm) : b;
        case (op)
            OP_AND:  return a & bb;
            OP_ORR:  return a | bb;
            OP_XOR:  return a ^ bb;
            OP_SHL:  return a << bb[3:0];
            OP_SHR:  return a >> bb[3:0];
            OP_ADD:  return a + bb;
            OP_SUB:  return a - bb;
            default: return '0;
        endcase
    endfunction

    // Stand-in for core_alu: result and destination registered one cycle after start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_wb_value <= '0;
            alu_wb_rd    <= '0;
        end else if (alu_start) begin
            alu_wb_value <= alu_ref(alu_op, alu_a, alu_b, alu_imm, alu_uses_imm);
            alu_wb_rd    <= alu_rd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every issued op waits in order and becomes visible two cycles later.
    typedef struct {
        int              id;
        logic [RD_W-1:0] rd;
        logic [W-1:0]    value;
        int              ready_at;
    } exp_t;

    exp_t             q[$];
    int               mptr = 0;
    int               cyc = 0;
    bit               have_last = 0;
    logic [2:0]       last_op;
    logic [W-1:0]     last_a;
    logic [W-1:0]     last_b;
    logic [IMM_W-1:0] last_imm;
    logic             last_ui;
    logic [RD_W-1:0]  last_rd;

    always @(negedge clk) begin
        if (rst) begin
            check("m_rst_req_ready", 32'(req_ready), 0);
            check("m_rst_alu_start", 32'(alu_start), 0);
            check("m_rst_rsp_valid", 32'(rsp_valid), 0);
            q.delete();
            mptr = 0;
            have_last = 0;
        end else begin
            bit exp_rv, pop, ok;
            int g, idx;
            exp_rv = (q.size() > 0) && (q[0].ready_at <= cyc);
            pop    = exp_rv && rsp_ready;
            ok     = (q.size() - int'(pop)) < DEPTH;
            g = -1;
            if (ok) begin
                for (int k = 0; k < N; k++) begin
                    idx = (mptr + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            check("m_req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            check("m_alu_start", 32'(alu_start), 32'(g >= 0));
            if (g >= 0) begin
                check("m_alu_op",  32'(alu_op),       32'(op_r[g]));
                check("m_alu_a",   32'(alu_a),        32'(a_r[g]));
                check("m_alu_b",   32'(alu_b),        32'(b_r[g]));
                check("m_alu_imm", 32'(alu_imm),      32'(imm_r[g]));
                check("m_alu_ui",  32'(alu_uses_imm), 32'(ui_r[g]));
                check("m_alu_rd",  32'(alu_rd),       32'(rd_r[g]));
            end else if (have_last) begin
                check("m_hold_op", 32'(alu_op), 32'(last_op));
                check("m_hold_a",  32'(alu_a),  32'(last_a));
                check("m_hold_rd", 32'(alu_rd), 32'(last_rd));
            end
            check("m_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv) begin
                check("m_rsp_id",    32'(rsp_id),    32'(q[0].id));
                check("m_rsp_rd",    32'(rsp_rd),    32'(q[0].rd));
                check("m_rsp_value", 32'(rsp_value), 32'(q[0].value));
            end
            if (dut.inflight)
                check("fifo_overflow", 32'(dut.fifo_count == DEPTH && !(rsp_valid && rsp_ready)), 0);
            if (pop) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{id: g, rd: rd_r[g],
                              value: alu_ref(op_r[g], a_r[g], b_r[g], imm_r[g], ui_r[g]),
                              ready_at: cyc + 2});
                mptr      = (g + 1) % N;
                have_last = 1;
                last_op   = op_r[g];
                last_a    = a_r[g];
                last_b    = b_r[g];
                last_imm  = imm_r[g];
                last_ui   = ui_r[g];
                last_rd   = rd_r[g];
            end
        end
        cyc++;
    end

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [IMM_W-1:0] imm,
                           input logic ui, input logic [RD_W-1:0] rd);
        op_r[i] = op; a_r[i] = a; b_r[i] = b; imm_r[i] = imm; ui_r[i] = ui; rd_r[i] = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string nm, input logic [ID_W-1:0] id, input logic [W-1:0] val);
        bit seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        if (!seen) check({nm, "_timeout"}, 0, 1);
        else begin
            check({nm, "_id"}, 32'(rsp_id), 32'(id));
            check({nm, "_value"}, 32'(rsp_value), 32'(val));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int grants;
        int skip_exp [3];
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, OP_AND, '0, '0, '0, 1'b0, '0);
        #1 rst = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_alu_start", 32'(alu_start), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        next_cycle();
        rst = 1'b0;

        // Single ADD from requester 2
        set_req(2, OP_ADD, 16'h0005, 16'h0003, 8'h00, 1'b0, 4'd7);
        req_valid = 4'b0100;
        @(negedge clk);
        check("single_req_ready", 32'(req_ready), 32'b0100);
        check("single_alu_start", 32'(alu_start), 1);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("single_rsp_early", 32'(rsp_valid), 0);
        @(negedge clk);
        check("single_rsp_valid", 32'(rsp_valid), 1);
        check("single_rsp_id",    32'(rsp_id), 2);
        check("single_rsp_rd",    32'(rsp_rd), 7);
        check("single_rsp_value", 32'(rsp_value), 32'h0008);

        // Round-robin: one grant to req 3 wraps the pointer to 0, then all four contend
        next_cycle();
        for (int i = 0; i < N; i++) set_req(i, OP_ADD, W'(16'h0100 * i), W'(i + 1), 8'h00, 1'b0, RD_W'(i));
        req_valid = 4'b1000;
        next_cycle();
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'd1 << (k % 4));
            next_cycle();
        end
        req_valid = '0;
        repeat (4) next_cycle();

        // Backpressure: only DEPTH ops issue while the consumer stalls
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        grants = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            grants += int'(req_ready[0]);
            next_cycle();
        end
        check("bp_grants", 32'(grants), DEPTH);
        @(negedge clk);
        check("bp_ready_stalled", 32'(req_ready), 0);
        check("bp_rsp_valid", 32'(rsp_valid), 1);
        next_cycle();
        rsp_ready = 1'b1;
        repeat (6) next_cycle();
        req_valid = '0;
        repeat (5) next_cycle();

        // Immediate path versus register path for SHL
        set_req(1, OP_SHL, 16'h0001, 16'h0007, 8'd4, 1'b1, 4'd3);
        req_valid = 4'b0010;
        @(negedge clk);
        check("imm_grant", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = '0;
        wait_rsp("shl_imm", 2'd1, 16'h0010);
        next_cycle();
        set_req(1, OP_SHL, 16'h0001, 16'h0002, 8'd4, 1'b0, 4'd3);
        req_valid = 4'b0010;
        next_cycle();
        req_valid = '0;
        wait_rsp("shl_reg", 2'd1, 16'h0004);
        next_cycle();

        // Pointer skip and wrap with only req 1 and req 3 valid, pointer cleared by reset
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        skip_exp = '{1, 3, 1};
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("skip_grant", 32'(req_ready), 32'd1 << skip_exp[k]);
            next_cycle();
        end
        req_valid = '0;
        repeat (4) next_cycle();

        // Reset the cycle after a grant: the in-flight op must vanish
        set_req(2, OP_ADD, 16'h1000, 16'h0234, 8'h00, 1'b0, 4'd9);
        set_req(0, OP_XOR, 16'h00FF, 16'h0F0F, 8'h00, 1'b0, 4'd5);
        req_valid = 4'b0100;
        @(negedge clk);
        check("mf_grant", 32'(req_ready), 32'b0100);
        next_cycle();
        rst = 1'b1;
        req_valid = 4'b0101;
        @(negedge clk);
        check("mf_rsp_valid", 32'(rsp_valid), 0);
        check("mf_req_ready", 32'(req_ready), 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("mf_first_grant", 32'(req_ready), 32'b0001);
        next_cycle();
        req_valid = '0;
        wait_rsp("mf_rsp", 2'd0, 16'h0FF0);
        next_cycle();

        // Randomized traffic with random consumer stalls
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 3'($urandom_range(0, 6)), W'($urandom), W'($urandom),
                        IMM_W'($urandom), 1'($urandom), RD_W'($urandom));
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) next_cycle();
        @(negedge clk);
        check("drain_rsp_valid", 32'(rsp_valid), 0);
        check("drain_model_empty", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
